// File: rtl/sdf_stage3_ctrl.sv
// Controller for a radix-2 single-delay-feedback FFT stage (delay depth 4, frame 32).
// Holds the sample register, the 4-entry feedback delay line, twiddle select and output register.
module sdf_stage3_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] in_r,
    input  logic [14:0] in_i,
    output logic [1:0]  bf_state,
    output logic [14:0] bf_A_r,
    output logic [14:0] bf_A_i,
    output logic [15:0] bf_B_r,
    output logic [15:0] bf_B_i,
    output logic [7:0]  bf_WN_r,
    output logic [7:0]  bf_WN_i,
    input  logic [15:0] bf_out_r,
    input  logic [15:0] bf_out_i,
    input  logic [15:0] bf_SR_r,
    input  logic [15:0] bf_SR_i,
    output logic        out_valid,
    output logic [15:0] out_r,
    output logic [15:0] out_i
);

    // state   | meaning
    // IDLE    | no held sample and no flush; everything holds
    // FIRST   | idx[2]=1: out = B+A, delay line takes B-A
    // SECOND  | pending group (or flush): out = B*W, delay line takes A
    // WAITING | idx[2]=0, nothing pending: delay line fills with A
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FIRST  = 2'd1;
    localparam logic [1:0] S_SECOND = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

    logic [4:0]  cnt;
    logic [4:0]  a_idx;
    logic        a_vld;
    logic [14:0] a_r;
    logic [14:0] a_i;
    logic [15:0] dl_r [4];
    logic [15:0] dl_i [4];

    logic        pending, pending_nxt;
    logic        fl_on, fl_on_nxt;
    logic [1:0]  fl_cnt, fl_cnt_nxt;
    logic        last31, last31_nxt;

    logic        flush_cyc;
    logic        proc_cyc;
    logic        accept;
    logic [1:0]  k;

    // Flush begins the very cycle after idx 31 if no new sample is held.
    assign flush_cyc = fl_on | (last31 & ~a_vld);
    assign proc_cyc  = a_vld | flush_cyc;
    assign in_ready  = ~flush_cyc;
    assign accept    = in_valid & in_ready;
    assign k         = a_vld ? a_idx[1:0] : fl_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            fl_on   <= 1'b0;
            fl_cnt  <= 2'd0;
            last31  <= 1'b0;
        end else begin
            pending <= pending_nxt;
            fl_on   <= fl_on_nxt;
            fl_cnt  <= fl_cnt_nxt;
            last31  <= last31_nxt;
        end
    end

    always_comb begin
        pending_nxt = pending;
        fl_on_nxt   = fl_on;
        fl_cnt_nxt  = fl_cnt;
        last31_nxt  = a_vld && (a_idx == 5'd31);
        if (bf_state == S_FIRST && k == 2'd3) begin
            pending_nxt = 1'b1;
        end else if (bf_state == S_SECOND && k == 2'd3) begin
            pending_nxt = 1'b0;
        end
        if (flush_cyc) begin
            fl_cnt_nxt = fl_cnt + 2'd1;
            fl_on_nxt  = (fl_cnt != 2'd3);
        end
    end

    always_comb begin
        bf_state = S_IDLE;
        bf_WN_r  = 8'd0;
        bf_WN_i  = 8'd0;
        if (a_vld) begin
            if (a_idx[2])     bf_state = S_FIRST;
            else if (pending) bf_state = S_SECOND;
            else              bf_state = S_WAIT;
        end else if (flush_cyc) begin
            bf_state = S_SECOND;
        end
        if (bf_state == S_SECOND) begin
            case (k)
                2'd0:    begin bf_WN_r = 8'd64;  bf_WN_i = 8'd0;   end
                2'd1:    begin bf_WN_r = 8'd45;  bf_WN_i = 8'hD3;  end
                2'd2:    begin bf_WN_r = 8'd0;   bf_WN_i = 8'hC0;  end
                default: begin bf_WN_r = 8'hD3;  bf_WN_i = 8'hD3;  end
            endcase
        end
    end

    assign bf_A_r = flush_cyc ? 15'd0 : a_r;
    assign bf_A_i = flush_cyc ? 15'd0 : a_i;
    assign bf_B_r = dl_r[3];
    assign bf_B_i = dl_i[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 5'd0;
            a_idx <= 5'd0;
            a_vld <= 1'b0;
            a_r   <= 15'd0;
            a_i   <= 15'd0;
        end else begin
            a_vld <= accept;
            if (accept) begin
                a_idx <= cnt;
                cnt   <= cnt + 5'd1;
                a_r   <= in_r;
                a_i   <= in_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) begin
                dl_r[n] <= 16'd0;
                dl_i[n] <= 16'd0;
            end
        end else if (proc_cyc) begin
            dl_r[0] <= bf_SR_r;
            dl_i[0] <= bf_SR_i;
            for (int n = 1; n < 4; n++) begin
                dl_r[n] <= dl_r[n-1];
                dl_i[n] <= dl_i[n-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_r     <= 16'd0;
            out_i     <= 16'd0;
        end else if (bf_state == S_FIRST || bf_state == S_SECOND) begin
            out_valid <= 1'b1;
            out_r     <= bf_out_r;
            out_i     <= bf_out_i;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/sdf_stage3_ctrl.md
SDF_STAGE3_CTRL -- requirements
Module: sdf_stage3_ctrl

Interface
REQ-001 The block SHALL have no parameters: delay depth 4 and frame length 32 are fixed.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 in_valid  in  1  input sample present this cycle.
REQ-006 in_ready  out  1  sample accepted when in_valid && in_ready.
REQ-007 in_r, in_i  in  15 each  signed input sample, 8 integer / 7 fractional bits.
REQ-008 bf_state  out  2  butterfly mode: IDLE=0, FIRST=1, SECOND=2, WAITING=3.
REQ-009 bf_A_r, bf_A_i  out  15 each  registered input sample driven to the butterfly A port.
REQ-010 bf_B_r, bf_B_i  out  16 each  delay-line tap 3 driven to the butterfly B port.
REQ-011 bf_WN_r, bf_WN_i  out  8 each  signed twiddle, 2 integer / 6 fractional bits.
REQ-012 bf_out_r, bf_out_i  in  16 each  butterfly result.
REQ-013 bf_SR_r, bf_SR_i  in  16 each  butterfly value to be written into the delay line.
REQ-014 out_valid  out  1  stage output valid.
REQ-015 out_r, out_i  out  16 each  registered stage output, 9 integer / 7 fractional bits.

Function
REQ-016 On each accepted sample, the block SHALL latch it into the A register with a 5-bit index idx (0..31, wrapping) and set a_vld; with no accepted sample, a_vld SHALL be 0 and the A register SHALL hold its value.
REQ-017 The state SHALL be decoded from the held sample (processing cycle = a_vld=1 or flush=1):
- idx[2]=1 -> FIRST.
- idx[2]=0 with no pending group -> WAITING.
- idx[2]=0 with a pending group -> SECOND.
- Flush cycle -> SECOND, with bf_A forced to 0.
- Otherwise -> IDLE.
REQ-018 The pending flag SHALL set after each FIRST cycle whose idx[1:0]=3, and SHALL clear after the 4th SECOND cycle of that group.
REQ-019 The delay line SHALL be 4 entries of complex 16-bit values; on every processing cycle, the entries SHALL shift by one, bf_SR SHALL load into entry 0, and bf_B SHALL equal entry 3.
REQ-020 Outside processing cycles, the delay line SHALL hold its contents.
REQ-021 The twiddle SHALL be selected by k = position within the SECOND run (idx[1:0] of the held sample, or the flush count):
- k=0: (64, 0)
- k=1: (45, -45)
- k=2: (0, -64)
- k=3: (-45, -45)
- Outside SECOND: (0, 0).
REQ-022 In FIRST and SECOND cycles, the block SHALL register bf_out into out_r/out_i and assert out_valid the next cycle; in all other cycles, out_valid SHALL be 0 and out_r/out_i SHALL hold their values.
REQ-023 Latency: the first output SHALL be valid 2 cycles after sample idx 4 is accepted, and each frame SHALL produce exactly 32 outputs.
REQ-024 Flush SHALL start in the cycle after idx 31 is processed if a_vld=0 in that cycle, and SHALL run 4 cycles with in_ready=0; in_valid during flush SHALL be ignored.
REQ-025 Back-to-back frames: if idx 0 of the next frame is held in the cycle right after idx 31, that sample SHALL be processed as SECOND and no flush SHALL occur.
REQ-026 A mid-frame gap (in_valid=0) SHALL stall the counter, delay line and pending flag; the output values SHALL be identical to those of a gapless run.
REQ-027 Outside flush, in_ready SHALL be 1.

Reset
REQ-028 While rst_n=0, the block SHALL drive the following:
- out_valid, out_r, out_i = 0.
- bf_state = IDLE.
- bf_A, bf_B, bf_WN = 0.
- idx, pending flag, flush counter and delay line cleared.
- in_ready = 1.
REQ-029 A reset asserted mid-frame or mid-flush SHALL discard all partial data, and the next accepted sample SHALL be idx 0 of a new frame.

Verification
REQ-030 Reset: assert rst_n=0 asynchronously mid-cycle -> all outputs 0, bf_state=0 and in_ready=1 immediately.
REQ-031 Impulse: x[0]=(128,0), all other samples 0, one frame -> 32 outputs with group 0 = 128,0,0,0,128,0,0,0 on out_r, all other outputs 0, and the first out_valid 2 cycles after x[4] is accepted.
REQ-032 Twiddle: x[5]=(0,128), others 0 -> output 1 = (0,128) and output 5 = (-90,-90).
REQ-033 Two frames back-to-back -> WAITING never occurs in frame 2, 64 outputs are produced, and in_ready stays 1.
REQ-034 Gaps: in_valid held low 3 cycles after x[10] and after x[31] -> output values match the gapless run, and a 4-cycle flush with in_ready=0 follows the last sample.
REQ-035 Reset after x[13], then the impulse frame -> outputs exactly match REQ-031.
